ppu_run_ctrl: RTL
=================

Name: ppu_run_ctrl

Overview:
Synthesizable run controller wrapping one ppu core with its instruction and data RAMs. It performs the full bring-up sequence in hardware: load IRAM from a byte stream, zero DRAM, hold the core in reset and release it, then run. Run ends on halt or a cycle budget, after which it streams the first DUMP_WORDS DRAM words out on a valid/ready port. The simulation top and FPGA wrappers both sit above it; there is no behavioural memory preload.

Parameters:
ADDR_W, 8, IRAM/DRAM address width.
DATA_W, 8, RAM word width.
RAM_SIZE, 256, words per RAM; must be <= 2**ADDR_W.
RUN_CYCLES, 1024, maximum core cycles before forced stop.
CNT_W, 16, run-counter width; must satisfy 2**CNT_W > RUN_CYCLES.
DUMP_WORDS, 10, DRAM words streamed out, starting at address 0; 1..RAM_SIZE.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-low reset.
start  in  1  single-cycle pulse; accepted only in IDLE or DONE.
load_len  in  ADDR_W+1  number of IRAM words to load, sampled on accepted start; 0 skips LOAD.
ld_valid  in  1  load byte valid.
ld_data  in  DATA_W  load byte.
ld_ready  out  1  load byte accepted when ld_valid && ld_ready.
iram_we  out  1  IRAM write enable.
iram_addr  out  ADDR_W  IRAM write address.
iram_wdata  out  DATA_W  IRAM write data.
dram_we  out  1  DRAM write enable, used for clearing.
dram_re  out  1  DRAM read enable, used for dumping.
dram_addr  out  ADDR_W  DRAM address.
dram_wdata  out  DATA_W  always 0.
dram_rdata  in  DATA_W  DRAM read data, valid one cycle after dram_re.
core_rst  out  1  active-low reset to the ppu core; 1 only in RUN.
core_halt  in  1  core halt flag; sampled only in RUN.
dp_valid  out  1  dump word valid.
dp_addr  out  ADDR_W  address of dumped word.
dp_data  out  DATA_W  dumped word.
dp_ready  in  1  dump consumer ready.
busy  out  1  state is neither IDLE nor DONE.
done  out  1  high in DONE.
timeout  out  1  sticky; set when RUN ended on budget; cleared on next accepted start.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all counters 0.
- Reset output values: core_rst=0; done=0; timeout=0; busy=0; ld_ready=0; dp_valid=0; all RAM enables 0.
- Reset mid-operation aborts immediately. No partial dump word is presented after reset is released.
- Outputs are registered except where stated otherwise.
- IDLE/DONE: on start, latch load_len, clear timeout and done, and go to LOAD. If load_len=0, go straight to CLEAR.
- LOAD:
  - ld_ready=1 combinationally in this state.
  - Each handshake writes ld_data to IRAM at address k, k=0..load_len-1, in the same cycle (iram_we=1).
  - After the load_len-th write, go to CLEAR.
  - load_len > RAM_SIZE is clamped to RAM_SIZE.
- CLEAR:
  - dram_we=1 with dram_addr=0..RAM_SIZE-1, one word per cycle.
  - Takes exactly RAM_SIZE cycles, then go to RUN.
- RUN:
  - core_rst=1 from the first RUN cycle.
  - Run counter starts at 0 and increments each cycle.
  - Leave RUN when core_halt=1 (timeout=0) or when the counter reaches RUN_CYCLES-1 (timeout=1).
  - If both occur in the same cycle, halt wins and timeout=0.
  - core_rst returns to 0 in the cycle after leaving RUN.
  - Next state is DUMP_RD.
- DUMP_RD: assert dram_re with dram_addr=j, then go to DUMP_OUT.
- DUMP_OUT:
  - Register dram_rdata into dp_data and drive dp_addr=j, dp_valid=1.
  - Hold all three stable until dp_ready=1.
  - On handshake: if j=DUMP_WORDS-1, go to DONE; otherwise j=j+1 and return to DUMP_RD.
  - Throughput is at most one word per 2 cycles.
- DONE: done=1, core held in reset. A new start re-runs the full sequence, and IRAM is reloaded.
- start outside IDLE/DONE is ignored.
- ld_valid outside LOAD is ignored, with no IRAM write.
- Address counters never wrap: LOAD and CLEAR stop at their terminal counts.

Test Plan:
- Load 4 bytes 01,02,03,04, core halts 20 cycles into RUN, DUMP_WORDS=10 -> IRAM[0..3]=01..04; DRAM fully written 0; 10 dump words with dp_addr 0..9; timeout=0; done=1.
- Core never halts, RUN_CYCLES=1024 -> core_rst high exactly 1024 cycles; timeout=1; dump still occurs.
- Consumer holds dp_ready=0 for 7 cycles on word 3 -> dp_data/dp_addr stable throughout; no word skipped or duplicated.
- ld_valid toggles every other cycle, load_len=256 -> exactly 256 IRAM writes at addresses 0..255; then CLEAR lasts 256 cycles.
- rst pulsed low during DUMP at word 5 -> dp_valid=0 and core_rst=0 immediately; state IDLE; a new start completes a full run.
- core_halt and budget expiry in the same cycle -> timeout=0; start pulsed during RUN -> ignored.

Source files
------------

// File: rtl/ppu_run_ctrl.sv
// Bring-up and run sequencer for one ppu core: streams a program into IRAM, zeroes DRAM,
// runs the core under a cycle budget, then streams the first DUMP_WORDS DRAM words out.
module ppu_run_ctrl #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int RAM_SIZE   = 256,
   parameter int RUN_CYCLES = 1024,
   parameter int CNT_W      = 16,
   parameter int DUMP_WORDS = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   load_len,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              iram_we,
   output logic [ADDR_W-1:0] iram_addr,
   output logic [DATA_W-1:0] iram_wdata,
   output logic              dram_we,
   output logic              dram_re,
   output logic [ADDR_W-1:0] dram_addr,
   output logic [DATA_W-1:0] dram_wdata,
   input  logic [DATA_W-1:0] dram_rdata,
   output logic              core_rst,
   input  logic              core_halt,
   output logic              dp_valid,
   output logic [ADDR_W-1:0] dp_addr,
   output logic [DATA_W-1:0] dp_data,
   input  logic              dp_ready,
   output logic              busy,
   output logic              done,
   output logic              timeout
);

   localparam int LEN_W = ADDR_W + 1;
   localparam logic [LEN_W-1:0] RAM_SIZE_L = LEN_W'(RAM_SIZE);
   localparam logic [LEN_W-1:0] CLR_LAST   = LEN_W'(RAM_SIZE - 1);
   localparam logic [LEN_W-1:0] DUMP_LAST  = LEN_W'(DUMP_WORDS - 1);
   localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(RUN_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_CLEAR,
      S_RUN,
      S_DUMP_RD,
      S_DUMP_OUT,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [LEN_W-1:0]  len_q;
   logic [LEN_W-1:0]  len_clamped;
   logic [LEN_W-1:0]  ld_cnt;
   logic [LEN_W-1:0]  clr_cnt;
   logic [LEN_W-1:0]  dp_idx;
   logic [CNT_W-1:0]  run_cnt;

   logic start_ok;
   logic ld_fire;
   logic ld_last;
   logic clr_last;
   logic run_last;
   logic run_exit;
   logic budget_hit;
   logic dp_fire;

   assign len_clamped = (load_len > RAM_SIZE_L) ? RAM_SIZE_L : load_len;
   assign start_ok    = start && ((state_q == S_IDLE) || (state_q == S_DONE));
   assign ld_fire     = (state_q == S_LOAD) && ld_valid;
   assign ld_last     = (ld_cnt == len_q - LEN_W'(1));
   assign clr_last    = (clr_cnt == CLR_LAST);
   assign run_last    = (run_cnt == RUN_LAST);
   assign run_exit    = (state_q == S_RUN) && (core_halt || run_last);
   // Halt has priority over budget expiry when both land in the same cycle.
   assign budget_hit  = (state_q == S_RUN) && run_last && !core_halt;
   assign dp_fire     = (state_q == S_DUMP_OUT) && dp_valid && dp_ready;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= S_IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      // NOTE: every variable gets a default before the case, so no path infers a latch.
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (start) state_d = (len_clamped == '0) ? S_CLEAR : S_LOAD;
         end
         S_LOAD: begin
            if (ld_valid && ld_last) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            if (clr_last) state_d = S_RUN;
         end
         S_RUN: begin
            if (core_halt || run_last) state_d = S_DUMP_RD;
         end
         S_DUMP_RD: begin
            state_d = S_DUMP_OUT;
         end
         S_DUMP_OUT: begin
            if (dp_valid && dp_ready) state_d = (dp_idx == DUMP_LAST) ? S_DONE : S_DUMP_RD;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Per-phase counters; each stops or returns to zero at its terminal count, never wraps.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_q   <= '0;
         ld_cnt  <= '0;
         clr_cnt <= '0;
         run_cnt <= '0;
         dp_idx  <= '0;
      end else begin
         if (start_ok) begin
            len_q  <= len_clamped;
            ld_cnt <= '0;
            dp_idx <= '0;
         end
         if (ld_fire && !ld_last) ld_cnt <= ld_cnt + LEN_W'(1);
         if (state_q == S_CLEAR) clr_cnt <= clr_last ? '0 : clr_cnt + LEN_W'(1);
         if (state_q == S_RUN) run_cnt <= run_exit ? '0 : run_cnt + CNT_W'(1);
         if (dp_fire && (dp_idx != DUMP_LAST)) dp_idx <= dp_idx + LEN_W'(1);
      end
   end

   // Status flags are flopped from the next state so they track the FSM cycle-exactly.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         core_rst <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         timeout  <= 1'b0;
      end else begin
         core_rst <= (state_d == S_RUN);
         busy     <= (state_d != S_IDLE) && (state_d != S_DONE);
         done     <= (state_d == S_DONE);
         if (start_ok)        timeout <= 1'b0;
         else if (budget_hit) timeout <= 1'b1;
      end
   end

   // The first DUMP_OUT cycle waits for the RAM read data, then the word is held until taken.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dp_valid <= 1'b0;
         dp_addr  <= '0;
         dp_data  <= '0;
      end else if ((state_q == S_DUMP_OUT) && !dp_valid) begin
         dp_valid <= 1'b1;
         dp_addr  <= dp_idx[ADDR_W-1:0];
         dp_data  <= dram_rdata;
      end else if (dp_fire) begin
         dp_valid <= 1'b0;
      end
   end

   assign ld_ready   = (state_q == S_LOAD);
   assign iram_we    = ld_fire;
   assign iram_addr  = ld_cnt[ADDR_W-1:0];
   assign iram_wdata = ld_data;

   assign dram_we    = (state_q == S_CLEAR);
   assign dram_re    = (state_q == S_DUMP_RD);
   assign dram_wdata = '0;

   always_comb begin
      dram_addr = '0;
      if (state_q == S_CLEAR)        dram_addr = clr_cnt[ADDR_W-1:0];
      else if (state_q == S_DUMP_RD) dram_addr = dp_idx[ADDR_W-1:0];
   end

endmodule
